// File: rtl/alu_result_stage.sv
// Registered ALU result stage: two-entry skid buffer with zero/negative flags stored at capture.
// Optional feature macro ALU_RESULT_STAGE_PARITY_EN adds a stored even-parity bit on out_parity.
//
// state | meaning
// EMPTY | no entry held, out_valid low
// ONE   | MAIN holds the head entry
// FULL  | MAIN holds head, SKID holds the next entry, in_ready low
module alu_result_stage #(
  parameter int BUS_WIDTH = 8,
  parameter int TAG_WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [BUS_WIDTH-1:0] in_result,
  input  logic [TAG_WIDTH-1:0] in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [BUS_WIDTH-1:0] out_result,
  output logic [TAG_WIDTH-1:0] out_tag,
  output logic                 out_zero,
`ifdef ALU_RESULT_STAGE_PARITY_EN
  output logic                 out_parity,
`endif
  output logic                 out_neg
);

  localparam logic [1:0] EMPTY = 2'b00;
  localparam logic [1:0] ONE   = 2'b01;
  localparam logic [1:0] FULL  = 2'b10;

  logic [1:0]           state_q;
  logic [1:0]           state_nxt;
  logic                 push;
  logic                 pop;
  logic                 load_main_in;
  logic                 load_skid_in;
  logic                 load_main_skid;
  logic                 in_zero;
  logic                 in_neg;
  logic [BUS_WIDTH-1:0] skid_result;
  logic [TAG_WIDTH-1:0] skid_tag;
  logic                 skid_zero;
  logic                 skid_neg;

  assign push    = in_valid & in_ready;
  assign pop     = out_valid & out_ready;
  assign in_zero = (in_result == '0);
  assign in_neg  = in_result[BUS_WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      in_ready <= 1'b1;
    end else begin
      state_q  <= state_nxt;
      in_ready <= (state_nxt != FULL);
    end
  end

  always_comb begin
    state_nxt = state_q;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (push) state_nxt = ONE;
        ONE: begin
          if (push && !pop)      state_nxt = FULL;
          else if (!push && pop) state_nxt = EMPTY;
        end
        FULL:    if (pop) state_nxt = ONE;
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Flush suppresses all loads so a discarded push never reaches storage.
  always_comb begin
    out_valid      = (state_q == ONE) || (state_q == FULL);
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    if (!flush) begin
      case (state_q)
        EMPTY: load_main_in = push;
        ONE: begin
          load_main_in = push & pop;
          load_skid_in = push & ~pop;
        end
        FULL:    load_main_skid = pop;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_result  <= '0;
      out_tag     <= '0;
      out_zero    <= 1'b0;
      out_neg     <= 1'b0;
      skid_result <= '0;
      skid_tag    <= '0;
      skid_zero   <= 1'b0;
      skid_neg    <= 1'b0;
    end else begin
      if (load_main_in) begin
        out_result <= in_result;
        out_tag    <= in_tag;
        out_zero   <= in_zero;
        out_neg    <= in_neg;
      end else if (load_main_skid) begin
        out_result <= skid_result;
        out_tag    <= skid_tag;
        out_zero   <= skid_zero;
        out_neg    <= skid_neg;
      end
      if (load_skid_in) begin
        skid_result <= in_result;
        skid_tag    <= in_tag;
        skid_zero   <= in_zero;
        skid_neg    <= in_neg;
      end
    end
  end

`ifdef ALU_RESULT_STAGE_PARITY_EN
  logic skid_parity;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_parity  <= 1'b0;
      skid_parity <= 1'b0;
    end else begin
      if (load_main_in)        out_parity <= ^in_result;
      else if (load_main_skid) out_parity <= skid_parity;
      if (load_skid_in)        skid_parity <= ^in_result;
    end
  end
`endif

endmodule
